// File: rtl/instr_fetch_ctl.sv
// Program store and branch-decision logic for one TIS-100 node: holds the loaded
// program, returns the word at the current IP and steers the IP register.
module instr_fetch_ctl #(
  parameter int DEPTH = 256,
  parameter int ACC_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:7]       Addr_instr,
  input  logic [0:ACC_W-1] acc,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic [0:17]      load_data,
  input  logic             load_last,
  output logic             load_ready,
  input  logic             run,
  output logic [0:17]      instr,
  output logic [0:1]       jmpCond,
  output logic             jmpInstr,
  output logic [0:7]       jAddr,
  output logic             running,
  output logic [0:8]       prog_len
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [0:4] OP_JMP = 5'h10;
  localparam logic [0:4] OP_JEZ = 5'h11;
  localparam logic [0:4] OP_JNZ = 5'h12;
  localparam logic [0:4] OP_JGZ = 5'h13;
  localparam logic [0:4] OP_JLZ = 5'h14;
  localparam logic [0:4] OP_JRO = 5'h15;

  localparam logic [0:1] JC_INC  = 2'b00;
  localparam logic [0:1] JC_REL  = 2'b01;
  localparam logic [0:1] JC_IMM  = 2'b10;
  localparam logic [0:1] JC_ZERO = 2'b11;

  state_t      state, state_nxt;
  logic [0:7]  wp;
  logic        wr_en;
  logic [0:17] mem [DEPTH];

  logic [0:4]        opcode;
  logic [0:7]        offset;
  logic              acc_ez, acc_lz, acc_gz;
  logic              cond_true;
  logic [8:0]        last_idx;
  logic signed [9:0] jro_t;
  logic [0:7]        jro_addr;

  assign wr_en = (state == LOAD) && load_valid && !load_start && load_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      prog_len <= '0;
      wp       <= '0;
    end else begin
      state <= state_nxt;
      if (load_start) begin
        prog_len <= '0;
        wp       <= '0;
      end else if (wr_en) begin
        prog_len <= prog_len + 9'd1;
        wp       <= wp + 8'd1;
      end
    end
  end

  // NOTE: the program store is deliberately not reset; it is a plain RAM
  // written only by the load stream.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= load_data;
  end

  // Asynchronous read: a same-cycle write to this address shows up after the edge.
  assign instr  = mem[Addr_instr];
  assign opcode = instr[0:4];
  assign offset = instr[10:17];

  assign acc_ez = (acc == '0);
  assign acc_lz = acc[0];
  assign acc_gz = !acc_lz && !acc_ez;

  assign last_idx = prog_len - 9'd1;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cond_true = 1'b0;
    case (opcode)
      OP_JMP:  cond_true = 1'b1;
      OP_JEZ:  cond_true = acc_ez;
      OP_JNZ:  cond_true = !acc_ez;
      OP_JGZ:  cond_true = acc_gz;
      OP_JLZ:  cond_true = acc_lz;
      default: cond_true = 1'b0;
    endcase
  end

  // Relative target at 10 bits so both underflow and overflow are visible before clamping.
  always_comb begin
    jro_t = $signed({2'b00, Addr_instr}) + $signed({{2{offset[0]}}, offset});
    if (jro_t < 10'sd0)
      jro_addr = '0;
    else if (jro_t > $signed({1'b0, last_idx}))
      jro_addr = last_idx[7:0];
    else
      jro_addr = jro_t[7:0];
  end

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    running    = 1'b0;
    jmpInstr   = 1'b0;
    jAddr      = '0;
    jmpCond    = JC_ZERO;

    case (state)
      IDLE: begin
        if (load_start)                   state_nxt = LOAD;
        else if (run && prog_len != '0)   state_nxt = RUN;
      end
      LOAD: begin
        load_ready = (prog_len != 9'd256);
        if (load_start)
          state_nxt = LOAD;
        else if (wr_en && (load_last || prog_len == 9'd255))
          state_nxt = IDLE;
      end
      RUN: begin
        running  = 1'b1;
        jmpInstr = (opcode >= OP_JMP) && (opcode <= OP_JRO);
        if (opcode == OP_JRO) jAddr = jro_addr;
        if ({1'b0, Addr_instr} >= prog_len)        jmpCond = JC_ZERO;
        else if (cond_true)                        jmpCond = JC_IMM;
        else if (opcode == OP_JRO)                 jmpCond = JC_REL;
        else if ({1'b0, Addr_instr} == last_idx)   jmpCond = JC_ZERO;
        else                                       jmpCond = JC_INC;
        if (load_start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_ctl.sv
// Self-checking bench for instr_fetch_ctl: directed scenarios plus randomized
// load/run traffic compared every cycle against a behavioural program model.
`timescale 1ns/1ps
module tb_instr_fetch_ctl;

  localparam int ACC_W = 11;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [0:7]       Addr_instr;
  logic [0:ACC_W-1] acc;
  logic             load_start, load_valid, load_last, run;
  logic [0:17]      load_data;
  logic             load_ready, jmpInstr, running;
  logic [0:17]      instr;
  logic [0:1]       jmpCond;
  logic [0:7]       jAddr;
  logic [0:8]       prog_len;

  instr_fetch_ctl #(.DEPTH(256), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Addr_instr (Addr_instr),
    .acc        (acc),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .run        (run),
    .instr      (instr),
    .jmpCond    (jmpCond),
    .jmpInstr   (jmpInstr),
    .jAddr      (jAddr),
    .running    (running),
    .prog_len   (prog_len)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: program image, length, and whether loading/running.
  int m_mem   [256];
  bit m_known [256];
  int m_len     = 0;
  bit m_loading = 1'b0;
  bit m_running = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_len     <= 0;
      m_loading <= 1'b0;
      m_running <= 1'b0;
    end else if (load_start) begin
      m_loading <= 1'b1;
      m_running <= 1'b0;
      m_len     <= 0;
    end else if (m_loading) begin
      if (load_valid && m_len < 256) begin
        m_mem[m_len]   <= int'(load_data);
        m_known[m_len] <= 1'b1;
        m_len          <= m_len + 1;
        if (load_last || m_len == 255) m_loading <= 1'b0;
      end
    end else if (!m_running && run && m_len != 0) begin
      m_running <= 1'b1;
    end
  end

  function automatic int sacc();
    int v;
    v = int'(acc);
    if (acc[0]) v -= (1 << ACC_W);
    return v;
  endfunction

  function automatic void expect_ctl(input int addr, input int a,
                                     output int jc, output int ji, output int ja);
    int w, op, off, t;
    jc = 3; ji = 0; ja = 0;
    if (!m_running) return;
    w   = m_mem[addr];
    op  = w >> 13;
    off = w & 255;
    if (off >= 128) off -= 256;
    ji = (op >= 16 && op <= 21) ? 1 : 0;
    if (op == 21) begin
      t = addr + off;
      if (t < 0) t = 0;
      if (t > m_len - 1) t = m_len - 1;
      ja = t;
    end
    if (addr >= m_len) jc = 3;
    else if (op == 16 || (op == 17 && a == 0) || (op == 18 && a != 0) ||
             (op == 19 && a > 0) || (op == 20 && a < 0)) jc = 2;
    else if (op == 21) jc = 1;
    else if (addr == m_len - 1) jc = 3;
    else jc = 0;
  endfunction

  function automatic int next_ip(input int addr);
    int jc, ji, ja;
    expect_ctl(addr, sacc(), jc, ji, ja);
    case (jc)
      0:       return (addr + 1) & 255;
      1:       return ja;
      2:       return m_mem[addr] & 255;
      default: return 0;
    endcase
  endfunction

  always @(negedge clk) begin : cmp
    int jc, ji, ja;
    expect_ctl(int'(Addr_instr), sacc(), jc, ji, ja);
    check("jmpCond", int'(jmpCond), jc);
    check("running", int'(running), int'(m_running));
    check("load_ready", int'(load_ready), (m_loading && m_len < 256) ? 1 : 0);
    check("prog_len", int'(prog_len), m_len);
    if (m_known[Addr_instr]) begin
      check("instr", int'(instr), m_mem[Addr_instr]);
      check("jmpInstr", int'(jmpInstr), ji);
      check("jAddr", int'(jAddr), ja);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input int words[$], input bit with_last);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    foreach (words[i]) begin
      load_data  = 18'(words[i]);
      load_valid = 1'b1;
      load_last  = with_last && (i == words.size() - 1);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic rand_load(input int words[$], input bit with_last);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    foreach (words[i]) begin
      while ($urandom_range(0, 3) == 0) begin
        load_valid = 1'b0;
        Addr_instr = 8'($urandom_range(0, 255));
        tick();
      end
      load_data  = 18'(words[i]);
      load_valid = 1'b1;
      load_last  = with_last && (i == words.size() - 1);
      Addr_instr = 8'($urandom_range(0, 255));
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic start_run();
    Addr_instr = '0;
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic ip_step();
    int nxt;
    nxt = next_ip(int'(Addr_instr));
    tick();
    Addr_instr = 8'(nxt);
    #1;
  endtask

  task automatic jro_case(input int off, input int exp_addr);
    int q[$];
    repeat (6) q.push_back(0);
    q[3] = (21 << 13) | (off & 255);
    load_prog(q, 1'b1);
    start_run();
    Addr_instr = 8'd3;
    #1;
    check("jro_jAddr", int'(jAddr), exp_addr);
    check("jro_jmpCond", int'(jmpCond), 1);
  endtask

  function automatic int rand_word(input int len);
    int op, tgt, r;
    r = $urandom_range(0, 9);
    if (r < 3)      op = 0;
    else if (r < 9) op = 16 + $urandom_range(0, 5);
    else            op = $urandom_range(0, 31);
    case ($urandom_range(0, 2))
      0:       tgt = $urandom_range(0, 255);
      1:       tgt = $urandom_range(0, len + 2);
      default: tgt = ($urandom_range(0, 16) - 8) & 255;
    endcase
    return (op << 13) | ($urandom_range(0, 31) << 8) | tgt;
  endfunction

  function automatic logic [0:ACC_W-1] rand_acc();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 11'd1;
      2:       return 11'h7FF;
      3:       return 11'h400;
      4:       return 11'h3FF;
      default: return ACC_W'($urandom_range(0, 2047));
    endcase
  endfunction

  int exp_ip [5] = '{0, 1, 2, 3, 0};
  int exp_jc [5] = '{0, 0, 0, 3, 0};

  initial begin
    int q[$];
    int len;
    rst_n = 1'b0; Addr_instr = '0; acc = '0; run = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    repeat (2) tick();
    check("rst_prog_len", int'(prog_len), 0);
    check("rst_load_ready", int'(load_ready), 0);
    check("rst_jmpCond", int'(jmpCond), 3);
    check("rst_running", int'(running), 0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a load.
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_data = 18'(i + 1); load_valid = 1'b1; tick();
    end
    load_valid = 1'b0;
    check("midload_len", int'(prog_len), 3);
    rst_n = 1'b0; #1;
    check("midrst_prog_len", int'(prog_len), 0);
    check("midrst_load_ready", int'(load_ready), 0);
    check("midrst_jmpCond", int'(jmpCond), 3);
    tick(); rst_n = 1'b1; tick();
    run = 1'b1; tick(); run = 1'b0; #1;
    check("empty_run_running", int'(running), 0);
    check("empty_run_jmpCond", int'(jmpCond), 3);

    // Four NOPs: the IP walks 0,1,2,3 and wraps.
    q.delete(); repeat (4) q.push_back(0);
    load_prog(q, 1'b1);
    start_run(); #1;
    for (int i = 0; i < 5; i++) begin
      check("nop_ip", int'(Addr_instr), exp_ip[i]);
      check("nop_jc", int'(jmpCond), exp_jc[i]);
      ip_step();
    end

    // Conditional jumps: JGZ 4 at word 2, JLZ 1 at word 3.
    q.delete(); repeat (5) q.push_back(0);
    q[2] = (19 << 13) | 4;
    q[3] = (20 << 13) | 1;
    load_prog(q, 1'b1);
    acc = 11'd5;
    start_run(); #1;
    ip_step(); ip_step();
    check("jgz_addr", int'(Addr_instr), 2);
    check("jgz_taken", int'(jmpCond), 2);
    check("jgz_jmpInstr", int'(jmpInstr), 1);
    ip_step();
    check("jgz_next_ip", int'(Addr_instr), 4);
    Addr_instr = 8'd2; acc = '0; #1;
    check("jgz_acc0", int'(jmpCond), 0);
    Addr_instr = 8'd3; acc = 11'h7FF; #1;
    check("jlz_neg", int'(jmpCond), 2);

    // JRO clamping at both ends of a six-word program.
    jro_case(-7, 0);
    jro_case(1, 4);
    jro_case(9, 5);

    // Full 256-word load with no load_last, then one extra offered word.
    q.delete();
    for (int i = 0; i < 256; i++) q.push_back((i * 37 + 5) & 'h3FFFF);
    load_prog(q, 1'b0);
    load_data = 18'h3FFFF; load_valid = 1'b1; tick(); load_valid = 1'b0;
    Addr_instr = 8'd0; #1;
    check("full_prog_len", int'(prog_len), 256);
    check("full_load_ready", int'(load_ready), 0);
    check("full_running", int'(running), 0);
    check("full_word0", int'(instr), 5);
    Addr_instr = 8'd255; #1;
    check("full_word255", int'(instr), 9440);

    // load_start while running: restart load, IP returns to 0.
    q.delete(); repeat (4) q.push_back(0);
    load_prog(q, 1'b1);
    start_run(); #1;
    ip_step(); ip_step();
    check("abort_addr", int'(Addr_instr), 2);
    load_start = 1'b1; load_valid = 1'b1; load_data = 18'h3F00F; #1;
    check("abort_jc_same_cycle", int'(jmpCond), 0);
    ip_step();
    load_start = 1'b0; load_valid = 1'b0; #1;
    check("abort_jc_load", int'(jmpCond), 3);
    check("abort_load_ready", int'(load_ready), 1);
    ip_step();
    check("abort_ip_zero", int'(Addr_instr), 0);
    load_data = 18'h01234; load_valid = 1'b1; load_last = 1'b1;
    tick();
    load_valid = 1'b0; load_last = 1'b0; #1;
    check("abort_prog_len", int'(prog_len), 1);
    check("abort_word0", int'(instr), 'h1234);

    // Randomized load/run traffic checked by the per-cycle compare.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      end
      len = $urandom_range(1, 40);
      q.delete();
      for (int j = 0; j < len; j++) q.push_back(rand_word(len));
      rand_load(q, $urandom_range(0, 4) != 0);
      start_run(); #1;
      for (int c = 0; c < 60; c++) begin
        acc = rand_acc();
        case ($urandom_range(0, 49))
          0: begin
            load_start = 1'b1; ip_step(); load_start = 1'b0;
          end
          1: begin
            Addr_instr = 8'($urandom_range(0, 255)); #1;
          end
          default: ;
        endcase
        ip_step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctl.md
Name: instr_fetch_ctl

Overview:
- Program-store and branch-decision block on the far side of the instruction-pointer path of one TIS-100 node.
- Holds the node program (up to 256 x 18-bit words) and accepts a sequential load stream.
- Returns instr for the current Addr_instr in the same cycle, and evaluates ACC against jump opcodes.
- Drives jmpCond, jmpInstr and jAddr back to the IP register, so the IP never leaves the loaded program.

Parameters:
- DEPTH, 256, program word count; address width fixed at 8.
- ACC_W, 11, signed ACC width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- Addr_instr  in  [0:7]  current IP from the IP register
- acc  in  [0:ACC_W-1]  signed accumulator, two's complement
- load_start  in  1  enter LOAD, clears program length
- load_valid  in  1  load_data valid
- load_data  in  [0:17]  program word
- load_last  in  1  qualifies final load word
- load_ready  out  1  block accepts load word this cycle
- run  in  1  leave IDLE, start execution at address 0
- instr  out  [0:17]  program word at Addr_instr, combinational
- jmpCond  out  [0:1]  00 increment, 01 take jAddr, 10 take instr[10:17], 11 go to 0
- jmpInstr  out  1  current opcode is a jump
- jAddr  out  [0:7]  JRO target
- running  out  1  state == RUN
- prog_len  out  [0:8]  loaded word count, 0..256

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, prog_len=0, write pointer wp=0.
  - Memory contents are not reset.
  - Outputs: load_ready=0, running=0, jmpCond=11.
- States:
  - IDLE: jmpCond=11 (holds IP at 0).
    - load_start -> LOAD.
    - run with prog_len!=0 -> RUN.
    - run with prog_len==0 is ignored.
  - LOAD: load_ready=1, jmpCond=11.
    - Entry clears wp and prog_len.
    - Each load_valid cycle writes mem[wp]=load_data, then wp+1 and prog_len+1.
    - load_last with load_valid, or the 256th word, -> IDLE.
    - Words are not accepted after 256 (load_ready=0).
  - RUN: running=1.
    - load_start -> LOAD, with priority over run, takes effect next edge.
    - The IP sees jmpCond=11 from that cycle on.
- load_start in any state restarts LOAD. An active load_valid in the same cycle is discarded.
- instr = mem[Addr_instr], asynchronous read. A write and a read of the same address in one cycle return the old word.
- Opcode = instr[0:4]; target/offset = instr[10:17].
  - JMP=5'h10, JEZ=5'h11, JNZ=5'h12, JGZ=5'h13, JLZ=5'h14, JRO=5'h15.
  - jmpInstr=1 for 10..15, only in RUN.
- Conditions on acc (signed):
  - EZ: acc==0.
  - NZ: acc!=0.
  - GZ: acc>0.
  - LZ: acc<0.
- jmpCond in RUN, first match wins:
  1. Addr_instr >= prog_len -> 11.
  2. JMP, or conditional jump with condition true -> 10.
  3. JRO -> 01.
  4. Addr_instr == prog_len-1 -> 11 (program wrap).
  5. Otherwise -> 00.
- JRO arithmetic:
  - t = Addr_instr + sign-extended offset, computed at 10 bits.
  - Clamp: t<0 -> 0; t>prog_len-1 -> prog_len-1.
  - jAddr = t[7:0].
  - jAddr = 0 when the current instruction is not JRO.
- A jump to an immediate >= prog_len is forwarded unchanged; rule 1 returns the IP to 0 on the following cycle.
- Latency: all control outputs are combinational from Addr_instr/acc/state. State, prog_len and mem update on clk.

Test Plan:
- Reset mid-LOAD after 3 words -> prog_len=0, IDLE, jmpCond=11. Subsequent run is ignored and jmpCond stays 11.
- Load 4 NOPs (opcode 0), run; IP register loop -> Addr_instr 0,1,2,3,0. jmpCond=11 at address 3, 00 elsewhere.
- Load 5 words with word2=JGZ 4:
  - acc=5 at address 2 -> jmpCond=10, next IP 4.
  - acc=0 -> jmpCond=00.
  - acc=-1 with JLZ -> jmpCond=10.
- Load 6 words, JRO at address 3:
  - offset -7 -> jAddr=0.
  - offset +1 -> jAddr=4.
  - offset +9 -> jAddr=5.
  - jmpCond=01 in every case.
- Load 256 words without load_last -> after the 256th word, IDLE, prog_len=256, load_ready=0; no wrap write to address 0.
- RUN at address 2, assert load_start -> next cycle LOAD, jmpCond=11, IP reaches 0. The first new word lands at address 0.
